key_priority_encoder: RTL

- Input-side counterpart of the 3-to-8 active-low LED decoder.
- Samples eight active-low switch lines, synchronises and debounces them, and detects new presses.
- Each press event is priority-encoded to a 3-bit key code and queued in a small FIFO.
- The queue drains over a valid/ready handshake to the consumer, which is typically the control logic that drives the LED decoder.

---
 rtl/key_priority_encoder_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/key_priority_encoder.sv | 76 +++++++
 3 files changed

// File: rtl/key_priority_encoder_pkg.sv
// Shared constants and types for the key input path and its LED decoder partner.
// The gate code here must match the one the LED decoder uses.
package key_priority_encoder_pkg;

   localparam logic [2:0] ENABLE_CODE = 3'b100;
   localparam int         KEY_W       = 8;
   localparam int         CODE_W      = 3;

   typedef logic [CODE_W-1:0] key_code_t;

   // Index of the highest set bit; bit KEY_W-1 wins. Returns 0 for an all-zero vector.
   function automatic key_code_t encode_msb(input logic [KEY_W-1:0] vec);
      key_code_t code;
      code = '0;
      for (int i = 0; i < KEY_W; i++) begin
         if (vec[i]) code = key_code_t'(i);
      end
      return code;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready read side and a sticky overflow flag.
// The head is shown combinationally from storage; it reads 0 while the FIFO is empty.
module sync_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data_out,
   output logic             overflow
);

   localparam int             AW         = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             pop;
   logic             wr_en;

   assign full     = (count == FULL_COUNT);
   assign valid    = (count != '0);
   assign pop      = valid && ready;
   // A pop on the same edge frees the slot, so a full FIFO can still take a push.
   assign wr_en    = push && (!full || pop);
   assign data_out = valid ? mem[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never seen.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/key_priority_encoder.sv
// Synchronises and debounces eight active-low keys, priority-encodes new presses
// and queues the key codes for a valid/ready consumer.
module key_priority_encoder
   import key_priority_encoder_pkg::*;
#(
   parameter int DEBOUNCE   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       enable,
   input  logic [KEY_W-1:0] keys_n,
   output logic             out_valid,
   output key_code_t        out_code,
   input  logic             out_ready,
   output logic             any_pressed,
   output logic             overflow
);

   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE - 1);

   logic [KEY_W-1:0] s1;
   logic [KEY_W-1:0] s2;
   logic [KEY_W-1:0] cand;
   logic [KEY_W-1:0] stable;
   logic [KEY_W-1:0] stable_q;
   logic [7:0]       cnt;
   logic [KEY_W-1:0] newpress;
   logic             push;
   key_code_t        code;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1       <= '1;
         s2       <= '1;
         cand     <= '1;
         stable   <= '1;
         stable_q <= '1;
         cnt      <= '0;
      end else begin
         s1       <= keys_n;
         s2       <= s1;
         stable_q <= stable;
         // Any change in the whole vector restarts the hold timer; cnt saturates at CNT_MAX.
         if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= cand;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // Active-low lines: a press is a stable bit falling from 1 to 0.
   assign newpress    = stable_q & ~stable;
   assign push        = (enable == ENABLE_CODE) && (newpress != '0);
   assign code        = encode_msb(newpress);
   assign any_pressed = ~&stable;

   sync_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .data_in  (code),
      .ready    (out_ready),
      .valid    (out_valid),
      .data_out (out_code),
      .overflow (overflow)
   );

endmodule
